// File: rtl/mem_responder.sv
// mem_responder
// Memory-side responder for the CPU bus. Each request is decoded once, when it
// is sampled in IDLE, and served from one of: the boot-ROM overlay, the IE
// register, the 127-byte HRAM, the FF50 boot-disable latch, or an external
// memory port (req/ack handshake with a timeout).
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   cpu_addr/wdata  request address / write data (held while pending)
//   cpu_rd/cpu_wr   request strobes (both high is a write)
//   cpu_rdata       read data, valid while cpu_ready pulses on a read
//   cpu_ready       single-cycle completion pulse
//   boot_addr/data  boot ROM lookup (data is combinational from the address)
//   ext_*           external port; ext_req held until ext_ack or timeout
//   ie_reg          interrupt-enable register
//   boot_en         boot overlay active; cleared by a nonzero FF50 write
//   bus_err         sticky external-timeout flag
module mem_responder #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    output logic [7:0]  boot_addr,
    input  logic [7:0]  boot_data,
    output logic        ext_req,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic        ext_ack,
    input  logic [7:0]  ext_rdata,
    output logic [7:0]  ie_reg,
    output logic        boot_en,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_INT      = 2'd1,
        S_EXT_WAIT = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    localparam logic [1:0] K_BOOT  = 2'd0;
    localparam logic [1:0] K_IE    = 2'd1;
    localparam logic [1:0] K_HRAM  = 2'd2;
    localparam logic [1:0] K_LATCH = 2'd3;

    // Last counter value before the access is abandoned: ext_req stays high
    // for exactly TIMEOUT cycles when no ack arrives.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_r, state_s;
    logic [1:0]  kind_r, kind_s;
    logic        is_int_s;
    logic [7:0]  int_rdata_s;
    logic        req_s;
    logic        req_wr_r;
    logic [7:0]  req_wdata_r;
    logic [6:0]  req_idx_r;

    logic [7:0]  rdata_r, rdata_s;
    logic        ready_r, ready_s;
    logic        ext_req_r, ext_req_s;
    logic        ext_we_r, ext_we_s;
    logic [15:0] ext_addr_r, ext_addr_s;
    logic [7:0]  ext_wdata_r, ext_wdata_s;
    logic [7:0]  ie_r, ie_s;
    logic        boot_en_r, boot_en_s;
    logic        bus_err_r, bus_err_s;
    logic [7:0]  cnt_r, cnt_s;

    logic [7:0]  hram_r [0:126];

    assign req_s     = cpu_rd | cpu_wr;
    assign boot_addr = cpu_addr[7:0];

    // Address decode in priority order, with the internal read value.
    // HRAM index is addr - FF80, which is simply the low 7 address bits.
    always_comb begin
        is_int_s    = 1'b1;
        kind_s      = K_BOOT;
        int_rdata_s = 8'hFF;
        if (boot_en_r && (cpu_addr < 16'h0100)) begin
            kind_s      = K_BOOT;
            int_rdata_s = boot_data;
        end else if (cpu_addr == 16'hFFFF) begin
            kind_s      = K_IE;
            int_rdata_s = ie_r;
        end else if (cpu_addr >= 16'hFF80) begin
            kind_s      = K_HRAM;
            int_rdata_s = hram_r[cpu_addr[6:0]];
        end else if (cpu_addr == 16'hFF50) begin
            kind_s      = K_LATCH;
            int_rdata_s = {7'b1111111, ~boot_en_r};
        end else begin
            is_int_s    = 1'b0;
            kind_s      = K_BOOT;
            int_rdata_s = 8'hFF;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req_s) begin
                    state_s = is_int_s ? S_INT : S_EXT_WAIT;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_INT:  state_s = S_DONE;
            S_EXT_WAIT: begin
                if (ext_ack || (cnt_r == TO_LAST)) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_EXT_WAIT;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Next values of the registered outputs. Internal reads are latched at
    // the sampling edge so the data is already valid while cpu_ready is high
    // in INT; internal writes land at the edge that ends INT.
    always_comb begin
        rdata_s     = rdata_r;
        ready_s     = 1'b0;
        ext_req_s   = ext_req_r;
        ext_we_s    = ext_we_r;
        ext_addr_s  = ext_addr_r;
        ext_wdata_s = ext_wdata_r;
        ie_s        = ie_r;
        boot_en_s   = boot_en_r;
        bus_err_s   = bus_err_r;
        cnt_s       = cnt_r;
        case (state_r)
            S_IDLE: begin
                if (req_s && is_int_s) begin
                    ready_s = 1'b1;
                    if (!cpu_wr) begin
                        rdata_s = int_rdata_s;
                    end else begin
                        rdata_s = rdata_r;
                    end
                end else if (req_s) begin
                    ext_req_s   = 1'b1;
                    ext_we_s    = cpu_wr;
                    ext_addr_s  = cpu_addr;
                    ext_wdata_s = cpu_wdata;
                    cnt_s       = 8'd0;
                end else begin
                    ready_s = 1'b0;
                end
            end
            S_INT: begin
                if (req_wr_r && (kind_r == K_IE)) begin
                    ie_s = req_wdata_r;
                end else if (req_wr_r && (kind_r == K_LATCH) && (req_wdata_r != 8'h00)) begin
                    boot_en_s = 1'b0;
                end else begin
                    ie_s = ie_r;
                end
            end
            S_EXT_WAIT: begin
                // An ack in the final timeout cycle takes precedence.
                if (ext_ack) begin
                    ext_req_s = 1'b0;
                    ready_s   = 1'b1;
                    if (!ext_we_r) begin
                        rdata_s = ext_rdata;
                    end else begin
                        rdata_s = rdata_r;
                    end
                end else if (cnt_r == TO_LAST) begin
                    ext_req_s = 1'b0;
                    ready_s   = 1'b1;
                    rdata_s   = 8'hFF;
                    bus_err_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            S_DONE:  ready_s = 1'b0;
            default: ready_s = 1'b0;
        endcase
    end

    // State and output registers, plus the captured request
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            rdata_r     <= 8'hFF;
            ready_r     <= 1'b0;
            ext_req_r   <= 1'b0;
            ext_we_r    <= 1'b0;
            ext_addr_r  <= 16'h0000;
            ext_wdata_r <= 8'h00;
            ie_r        <= 8'h00;
            boot_en_r   <= 1'b1;
            bus_err_r   <= 1'b0;
            cnt_r       <= 8'd0;
            kind_r      <= K_BOOT;
            req_wr_r    <= 1'b0;
            req_wdata_r <= 8'h00;
            req_idx_r   <= 7'd0;
        end else begin
            state_r     <= state_s;
            rdata_r     <= rdata_s;
            ready_r     <= ready_s;
            ext_req_r   <= ext_req_s;
            ext_we_r    <= ext_we_s;
            ext_addr_r  <= ext_addr_s;
            ext_wdata_r <= ext_wdata_s;
            ie_r        <= ie_s;
            boot_en_r   <= boot_en_s;
            bus_err_r   <= bus_err_s;
            cnt_r       <= cnt_s;
            if ((state_r == S_IDLE) && req_s) begin
                kind_r      <= kind_s;
                req_wr_r    <= cpu_wr;
                req_wdata_r <= cpu_wdata;
                req_idx_r   <= cpu_addr[6:0];
            end
        end
    end

    // HRAM storage; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (rst && (state_r == S_INT) && req_wr_r && (kind_r == K_HRAM)) begin
            hram_r[req_idx_r] <= req_wdata_r;
        end
    end

    assign cpu_rdata = rdata_r;
    assign cpu_ready = ready_r;
    assign ext_req   = ext_req_r;
    assign ext_we    = ext_we_r;
    assign ext_addr  = ext_addr_r;
    assign ext_wdata = ext_wdata_r;
    assign ie_reg    = ie_r;
    assign boot_en   = boot_en_r;
    assign bus_err   = bus_err_r;

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU bus. The sequencer/decoder drives the address bus and data bus each step; this block serves those accesses. It decodes each request and serves it from one of four sources: internal HRAM (FF80–FFFE), the IE register (FFFF), the boot-ROM overlay with its FF50 disable latch, or an external memory port using a req/ack handshake with timeout. It sits between the CPU core and the cartridge/WRAM/peripheral fabric.

## Interface
Parameters:
- TIMEOUT, 64: max cycles ext_req stays high without ext_ack before the access is aborted (range 2–255).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- cpu_addr  in  16  request address; stable while request pending
- cpu_wdata  in  8  write data
- cpu_rd  in  1  read request
- cpu_wr  in  1  write request
- cpu_rdata  out  8  read data, valid when cpu_ready=1 on a read
- cpu_ready  out  1  one-cycle completion pulse
- boot_addr  out  8  boot ROM address
- boot_data  in  8  boot ROM data, combinational from boot_addr
- ext_req  out  1  external request, held until ext_ack
- ext_we  out  1  external write enable, valid with ext_req
- ext_addr  out  16  external address, valid with ext_req
- ext_wdata  out  8  external write data, valid with ext_req
- ext_ack  in  1  external completion, single-cycle
- ext_rdata  in  8  external read data, valid with ext_ack
- ie_reg  out  8  interrupt-enable register
- boot_en  out  1  boot overlay active
- bus_err  out  1  sticky, set on external timeout

## Operation
- States: IDLE, INT, EXT_WAIT, DONE.
- IDLE: a request is sampled when cpu_rd|cpu_wr=1. If both are high, treat it as a write.
- Address decode priority:
  1. boot_en && addr<0x0100 → boot, read-only. Writes are ignored and still complete.
  2. FFFF → IE.
  3. FF80–FFFE → HRAM, 127×8, index addr−0xFF80.
  4. FF50 → boot latch. Reads return {7'b1111111, ~boot_en}. A write with nonzero data clears boot_en; it stays cleared until reset. A write of 0 has no effect. The access is not forwarded externally.
  5. Everything else → external.
- Internal access (boot/IE/HRAM/FF50): IDLE→INT. In INT, perform the write or latch the read data, then pulse cpu_ready and go to DONE.
- External access: IDLE→EXT_WAIT.
  - ext_req=1 with addr/we/wdata registered from the request; all held constant until exit.
  - On ext_ack: capture ext_rdata (reads), drop ext_req, pulse cpu_ready, go to DONE.
- Timeout: a counter clears on entry to EXT_WAIT and increments each cycle without ack.
  - When it reaches TIMEOUT with no ack: drop ext_req, return cpu_rdata=0xFF, pulse cpu_ready, set bus_err, go to DONE.
  - If ack and timeout occur in the same cycle, the ack wins: no error, real data returned.
- DONE: one dead cycle, then IDLE. New requests are not sampled in DONE. The CPU removes or changes its request after seeing cpu_ready.
- cpu_rdata holds its last value until the next completed read. Writes leave it unchanged.
- HRAM contents are not reset.

## Timing
- Reset values (take effect the cycle after rst sampled low):
  - state=IDLE, cpu_ready=0, cpu_rdata=0xFF
  - ext_req=0, ext_we=0, ext_addr=0, ext_wdata=0
  - ie_reg=0x00, boot_en=1, bus_err=0, timeout counter=0
- Reset mid-operation aborts the access. ext_req is low the cycle after reset is sampled, and no cpu_ready pulse is issued.
- Internal latency: request sampled at edge N → cpu_ready high during cycle N+1.
- External latency: sampled at N → ext_req high from N+1. ext_ack seen at edge M → cpu_ready high during M+1 and ext_req low from M+1.
- Throughput: at most one access per 3 cycles for internal accesses (IDLE→INT→DONE).
- cpu_ready is never high for two consecutive cycles.
- ext_ack while ext_req=0 is ignored.
- Writes take effect at the edge ending INT, or on ack for external writes.
- boot_en falls at the edge ending INT of the FF50 write. The very next access to addr<0x0100 goes external.

## Test plan
- Write HRAM 0xFF80=0x5A, then read 0xFF80 → cpu_rdata=0x5A; each cpu_ready pulse comes 1 cycle after sampling. Read 0xFFFE after writing it 0xC3 → 0xC3.
- With boot_en=1, read 0x0042 with boot_data=0x31 → 0x31 and no ext_req. Write 0x01 to FF50. Read 0x0042 → ext_req=1, ext_addr=0x0042; ext_ack with ext_rdata=0x77 → 0x77. Read FF50 → 0xFF.
- Write FF50=0x00 → boot_en stays 1. Write 0x0010=0xAB during boot → no effect, cpu_ready pulses, no ext_req.
- External read of 0xC000 with ext_ack 5 cycles later, ext_rdata=0x99 → ext_req high exactly 5 cycles, cpu_rdata=0x99, bus_err=0.
- External write with no ack → ext_req drops after TIMEOUT cycles, cpu_ready pulses, bus_err=1 (sticky). Repeat with ack in the timeout cycle → no error.
- Assert rst during EXT_WAIT → next cycle ext_req=0, cpu_ready=0, ie_reg=0x00, boot_en=1, bus_err=0. Write IE=0x1F → ie_reg=0x1F.
